// File: rtl/tlu_handshake_ctrl.sv
// tlu_handshake_ctrl: sequences the TLU trigger/busy/clock handshake and hands each
// trigger record to the event builder over TRIG_VALID/TRIG_READY.
// Latency: TLU_TRIGGER reaches the FSM after a 2-FF synchroniser; TRIG_VALID is registered.
// Backpressure: TRIG_VALID/TRIG_ID are held until TRIG_READY; TLU_BUSY stays high
// meanwhile (modes 1/2), so the TLU is held off.
// Ports: SYS_CLK/SYS_RST clock and async reset; ENABLE/MODE/VETO control; TLU_TRIGGER,
// TLU_RESET in and TLU_BUSY, TLU_CLOCK out to the TLU; TRIG_VALID/TRIG_READY/TRIG_ID
// record handshake; TIMEOUT_ERR pulse; TRIG_CNT/SKIP_CNT statistics.
module tlu_handshake_ctrl #(
   parameter int TRIG_ID_BITS = 15,
   parameter int CLK_DIV      = 4,
   parameter int TIMEOUT      = 1023
) (
   input  logic                    SYS_CLK,
   input  logic                    SYS_RST,
   input  logic                    ENABLE,
   input  logic [1:0]              MODE,
   input  logic                    VETO,
   input  logic                    TLU_TRIGGER,
   input  logic                    TLU_RESET,
   output logic                    TLU_BUSY,
   output logic                    TLU_CLOCK,
   output logic                    TRIG_VALID,
   input  logic                    TRIG_READY,
   output logic [TRIG_ID_BITS-1:0] TRIG_ID,
   output logic                    TIMEOUT_ERR,
   output logic [31:0]             TRIG_CNT,
   output logic [15:0]             SKIP_CNT
);

   localparam int DIV_W = $clog2(2 * CLK_DIV);
   localparam int BIT_W = $clog2(TRIG_ID_BITS + 2);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HI   = DIV_W'(CLK_DIV);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TRIG_ID_BITS);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_BUSY_WAIT, S_SHIFT, S_OUT, S_DEAD
   } state_t;

   state_t r_state, w_state_nxt;

   logic                    r_trig_s1, r_trig_s2, r_trig_d;
   logic                    r_rst_s1, r_rst_s2;
   logic [1:0]              r_mode;
   logic [TMO_W-1:0]        r_tmo;
   logic                    r_low;
   logic [DIV_W-1:0]        r_div;
   logic [BIT_W-1:0]        r_bit;
   logic [TRIG_ID_BITS-2:0] r_sh;
   logic [TRIG_ID_BITS-1:0] r_cnt;

   logic [1:0]              w_mode_in, w_mode;
   logic                    w_trig, w_trig_rise;
   logic                    w_load_cnt, w_hs, w_tmo, w_skip, w_shift_done, w_sample;
   logic [DIV_W-1:0]        w_div_nxt;
   logic [TRIG_ID_BITS-1:0] w_sh_nxt;
   logic                    w_busy_nxt;

   // Mode 3 is an alias of mode 0; the mode is frozen once a sequence leaves IDLE.
   assign w_mode_in   = (MODE == 2'd3) ? 2'd0 : MODE;
   assign w_mode      = (r_state == S_IDLE) ? w_mode_in : r_mode;
   assign w_trig      = r_trig_s2;
   assign w_trig_rise = r_trig_s2 & ~r_trig_d;
   // LSB-first shift: the newest sample enters at the top of the window.
   assign w_sh_nxt    = {w_trig, r_sh};

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_load_cnt   = 1'b0;
      w_hs         = 1'b0;
      w_tmo        = 1'b0;
      w_skip       = 1'b0;
      w_shift_done = 1'b0;
      w_sample     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ENABLE && !VETO) begin
               if (w_mode == 2'd0) begin
                  if (w_trig_rise) begin
                     w_state_nxt = S_OUT;
                     w_load_cnt  = 1'b1;
                  end
               end else if (w_trig) begin
                  w_state_nxt = S_BUSY_WAIT;
               end
            end
         end
         S_BUSY_WAIT: begin
            if (!w_trig) begin
               if (r_mode == 2'd2) begin
                  w_state_nxt = S_SHIFT;
               end else begin
                  w_state_nxt = S_OUT;
                  w_load_cnt  = 1'b1;
               end
            end else if (r_tmo == TMO_LAST) begin
               w_state_nxt = S_DEAD;
               w_tmo       = 1'b1;
            end
         end
         S_SHIFT: begin
            // Sample on the last cycle of each low phase; period 0 carries the start bit.
            if (r_div == DIV_LAST) begin
               w_sample = (r_bit != '0);
               if (r_bit == BIT_LAST) begin
                  w_state_nxt  = S_OUT;
                  w_shift_done = 1'b1;
               end
            end
         end
         S_OUT: begin
            // In simple mode the TLU is not held off, so edges arriving now are lost.
            if (r_mode == 2'd0 && w_trig_rise) w_skip = 1'b1;
            if (TRIG_READY) begin
               w_hs        = 1'b1;
               w_state_nxt = (r_mode == 2'd0) ? S_IDLE : S_DEAD;
            end
         end
         S_DEAD: begin
            if (!w_trig && r_low) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_div_nxt = '0;
      if (r_state == S_SHIFT && r_div != DIV_LAST) w_div_nxt = r_div + 1'b1;
   end

   assign w_busy_nxt = (w_mode != 2'd0) &&
                       (w_state_nxt == S_BUSY_WAIT || w_state_nxt == S_SHIFT ||
                        w_state_nxt == S_OUT);

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         r_trig_s1   <= 1'b0;
         r_trig_s2   <= 1'b0;
         r_trig_d    <= 1'b0;
         r_rst_s1    <= 1'b0;
         r_rst_s2    <= 1'b0;
         r_mode      <= 2'd0;
         r_tmo       <= '0;
         r_low       <= 1'b0;
         r_div       <= '0;
         r_bit       <= '0;
         r_sh        <= '0;
         r_cnt       <= '0;
         TLU_BUSY    <= 1'b0;
         TLU_CLOCK   <= 1'b0;
         TRIG_VALID  <= 1'b0;
         TRIG_ID     <= '0;
         TIMEOUT_ERR <= 1'b0;
         TRIG_CNT    <= '0;
         SKIP_CNT    <= '0;
      end else begin
         r_trig_s1 <= TLU_TRIGGER;
         r_trig_s2 <= r_trig_s1;
         r_trig_d  <= r_trig_s2;
         r_rst_s1  <= TLU_RESET;
         r_rst_s2  <= r_rst_s1;

         if (r_state == S_IDLE) r_mode <= w_mode_in;

         if (r_state == S_BUSY_WAIT) r_tmo <= r_tmo + 1'b1;
         else                        r_tmo <= '0;

         // Set after one low cycle in DEAD; a second low cycle then releases.
         r_low <= (r_state == S_DEAD) && !w_trig;

         r_div <= w_div_nxt;
         if (r_state != S_SHIFT)       r_bit <= '0;
         else if (r_div == DIV_LAST)   r_bit <= r_bit + 1'b1;

         if (w_sample) r_sh <= w_sh_nxt[TRIG_ID_BITS-1:1];

         if (r_rst_s2)        r_cnt <= '0;
         else if (w_load_cnt) r_cnt <= r_cnt + 1'b1;

         if (w_load_cnt)        TRIG_ID <= r_cnt;
         else if (w_shift_done) TRIG_ID <= w_sh_nxt;

         // TLU_CLOCK is registered so the TLU sees a clean, glitch-free edge.
         TLU_CLOCK   <= (w_state_nxt == S_SHIFT) && (w_div_nxt < DIV_HI);
         TLU_BUSY    <= w_busy_nxt;
         TRIG_VALID  <= (w_state_nxt == S_OUT);
         TIMEOUT_ERR <= w_tmo;

         if (w_hs) TRIG_CNT <= TRIG_CNT + 32'd1;
         if (w_skip && SKIP_CNT != 16'hFFFF) SKIP_CNT <= SKIP_CNT + 16'd1;
      end
   end

endmodule

// File: tb/tb_tlu_handshake_ctrl.sv
// tb_tlu_handshake_ctrl: drives the controller from a behavioural TLU model and
// directed sequences, and checks every cycle against a record scoreboard.
// Single stimulus process; all time advances through tick().
module tb_tlu_handshake_ctrl;

   localparam int NB = 15;

   logic          SYS_CLK = 1'b0;
   logic          SYS_RST = 1'b0;
   logic          ENABLE = 1'b1;
   logic [1:0]    MODE = 2'd0;
   logic          VETO = 1'b0;
   logic          TLU_TRIGGER = 1'b0;
   logic          TLU_RESET = 1'b0;
   logic          TLU_BUSY, TLU_CLOCK, TRIG_VALID, TIMEOUT_ERR;
   logic          TRIG_READY = 1'b0;
   logic [NB-1:0] TRIG_ID;
   logic [31:0]   TRIG_CNT;
   logic [15:0]   SKIP_CNT;

   tlu_handshake_ctrl #(.TRIG_ID_BITS(NB), .CLK_DIV(4), .TIMEOUT(15)) dut (
      .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .ENABLE(ENABLE), .MODE(MODE), .VETO(VETO),
      .TLU_TRIGGER(TLU_TRIGGER), .TLU_RESET(TLU_RESET), .TLU_BUSY(TLU_BUSY),
      .TLU_CLOCK(TLU_CLOCK), .TRIG_VALID(TRIG_VALID), .TRIG_READY(TRIG_READY),
      .TRIG_ID(TRIG_ID), .TIMEOUT_ERR(TIMEOUT_ERR), .TRIG_CNT(TRIG_CNT), .SKIP_CNT(SKIP_CNT)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   int n_vec = 0;
   int n_err = 0;

   // scoreboard / model state
   logic [NB-1:0] exp_q[$];
   logic [NB-1:0] exp_id, last_id, p_id, tm_bits;
   int m_mode = 0, m_cnt = 0, m_ctr = 0, tlu_num = 0;
   int cyc = 0, rises = 0, first_rise = 0, tmo_seen = 0, vld_cyc = 0;
   logic p_vld = 1'b0, p_rdy = 1'b0, p_hs = 1'b0, p_clk = 1'b0, hs;
   // TLU model state
   int tm_state = 0, tm_start = 0, tm_edge = 0, tm_gap = 0, issued = 0;
   logic tm_en = 1'b1, tm_clk_d = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      cyc++;
      chk("trig_cnt", 64'(TRIG_CNT), 64'(m_cnt));
      if (TLU_CLOCK) chk("clock_only_while_busy", 64'(TLU_BUSY), 64'd1);
      if (TLU_CLOCK && !p_clk) begin
         rises++;
         if (rises == 1) first_rise = cyc;
      end
      if (p_hs) begin
         chk("valid_clears_after_hs", 64'(TRIG_VALID), 64'd0);
         if (m_mode != 0) chk("busy_clears_after_hs", 64'(TLU_BUSY), 64'd0);
      end else if (p_vld && !p_rdy) begin
         chk("valid_held", 64'(TRIG_VALID), 64'd1);
         chk("id_held", 64'(TRIG_ID), 64'(p_id));
      end
      if (TRIG_VALID && m_mode != 0) chk("busy_during_out", 64'(TLU_BUSY), 64'd1);
      if (TRIG_VALID && !p_vld && m_mode == 2)
         chk("shift_length", 64'(cyc - first_rise), 64'd128);
      hs = TRIG_VALID && TRIG_READY;
      if (hs) begin
         if (exp_q.size() == 0) begin
            chk("record_expected", 64'(exp_q.size()), 64'd1);
         end else begin
            exp_id = exp_q.pop_front();
            chk("trig_id", 64'(TRIG_ID), 64'(exp_id));
         end
         last_id = TRIG_ID;
         chk("clock_rises", 64'(rises), (m_mode == 2) ? 64'd16 : 64'd0);
         rises = 0;
         m_cnt++;
      end
      if (TIMEOUT_ERR) tmo_seen++;
      if (TRIG_VALID) vld_cyc++;
      p_vld = TRIG_VALID; p_rdy = TRIG_READY; p_hs = hs; p_id = TRIG_ID; p_clk = TLU_CLOCK;
   endtask

   // EUDAQ-style TLU: raise trigger, drop it on BUSY, then serve a zero start bit
   // followed by the trigger number LSB first, one bit per TLU_CLOCK rising edge.
   task automatic tlu_model();
      logic rise;
      rise = TLU_CLOCK && !tm_clk_d;
      tm_clk_d = TLU_CLOCK;
      if (!tm_en) return;
      case (tm_state)
         0: if (tm_start > 0 && !TLU_BUSY) begin
               TLU_TRIGGER = 1'b1;
               tm_start--;
               issued++;
               tm_bits = NB'(tlu_num);
               if (m_mode == 2) exp_q.push_back(NB'(tlu_num));
               else begin exp_q.push_back(NB'(m_ctr)); m_ctr++; end
               tlu_num++;
               tm_state = 1;
            end
         1: if (TLU_BUSY) begin
               TLU_TRIGGER = 1'b0;
               tm_edge = 0;
               tm_gap = 0;
               tm_state = (m_mode == 2) ? 2 : 3;
            end
         2: begin
               if (rise) begin
                  tm_edge++;
                  TLU_TRIGGER = (tm_edge >= 2) ? tm_bits[tm_edge-2] : 1'b0;
               end
               if (!TLU_BUSY) begin TLU_TRIGGER = 1'b0; tm_gap = 0; tm_state = 3; end
            end
         default: begin
               TLU_TRIGGER = 1'b0;
               if (!TLU_BUSY) begin
                  tm_gap++;
                  if (tm_gap >= 8) tm_state = 0;
               end
            end
      endcase
   endtask

   task automatic tick();
      @(negedge SYS_CLK);
      monitor();
      @(posedge SYS_CLK);
      #1;
      tlu_model();
   endtask

   task automatic model_reset();
      tm_state = 0; tm_start = 0; issued = 0; tlu_num = 0; TLU_TRIGGER = 1'b0;
      exp_q.delete();
      m_cnt = 0; m_ctr = 0; rises = 0; tmo_seen = 0; vld_cyc = 0;
      p_vld = 1'b0; p_hs = 1'b0; p_clk = 1'b0;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_busy"},  64'(TLU_BUSY), 64'd0);
      chk({nm, "_clock"}, 64'(TLU_CLOCK), 64'd0);
      chk({nm, "_valid"}, 64'(TRIG_VALID), 64'd0);
      chk({nm, "_id"},    64'(TRIG_ID), 64'd0);
      chk({nm, "_tmo"},   64'(TIMEOUT_ERR), 64'd0);
      chk({nm, "_cnt"},   64'(TRIG_CNT), 64'd0);
      chk({nm, "_skip"},  64'(SKIP_CNT), 64'd0);
   endtask

   task automatic do_reset(input int mode);
      SYS_RST = 1'b1;
      #1;
      model_reset();
      MODE = 2'(mode); m_mode = mode; TRIG_READY = 1'b1; VETO = 1'b0; ENABLE = 1'b1;
      tm_en = 1'b1;
      tick(); tick();
      SYS_RST = 1'b0;
      tick(); tick();
   endtask

   task automatic run_until_done(input int max_cyc);
      int n = 0;
      while (!(tm_state == 0 && tm_start == 0 && exp_q.size() == 0 && !TLU_BUSY &&
               !TRIG_VALID) && n < max_cyc) begin
         tick();
         n++;
      end
      chk("done_within_budget", 64'(n < max_cyc), 64'd1);
   endtask

   task automatic pulse();
      TLU_TRIGGER = 1'b1;
      repeat (4) tick();
      TLU_TRIGGER = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      int n;
      #1 SYS_RST = 1'b1;
      #1 chk_all_zero("reset");
      tick();
      SYS_RST = 1'b0;

      // Mode 2: five triggers, IDs 0..4 shifted in from the TLU.
      do_reset(2);
      tm_start = 5;
      run_until_done(3000);
      chk("m2_trig_cnt", 64'(TRIG_CNT), 64'd5);
      chk("m2_last_id", 64'(last_id), 64'd4);

      // Mode 2 with back-pressure: BUSY held, TLU issues nothing new.
      do_reset(2);
      TRIG_READY = 1'b0;
      tm_start = 2;
      n = 0;
      while (!TRIG_VALID && n < 400) begin tick(); n++; end
      chk("bp_valid_seen", 64'(TRIG_VALID), 64'd1);
      repeat (50) begin
         tick();
         chk("bp_busy_high", 64'(TLU_BUSY), 64'd1);
      end
      chk("bp_no_new_trigger", 64'(issued), 64'd1);
      chk("bp_first_id", 64'(TRIG_ID), 64'd0);
      TRIG_READY = 1'b1;
      run_until_done(1000);
      chk("bp_trig_cnt", 64'(TRIG_CNT), 64'd2);
      chk("bp_last_id", 64'(last_id), 64'd1);

      // Mode 1: three triggers, IDs from the internal counter, no TLU_CLOCK.
      do_reset(1);
      tm_start = 3;
      run_until_done(600);
      chk("m1_trig_cnt", 64'(TRIG_CNT), 64'd3);
      chk("m1_last_id", 64'(last_id), 64'd2);

      // VETO holds off acceptance while the TLU keeps TRIGGER high.
      do_reset(1);
      VETO = 1'b1;
      tm_start = 1;
      repeat (20) begin
         tick();
         chk("veto_busy_low", 64'(TLU_BUSY), 64'd0);
      end
      VETO = 1'b0;
      n = 0;
      while (!TLU_BUSY && n < 10) begin tick(); n++; end
      chk("veto_busy_latency", 64'(n >= 1 && n <= 2), 64'd1);
      run_until_done(300);
      chk("veto_one_record", 64'(TRIG_CNT), 64'd1);

      // Timeout: TRIGGER stuck high in BUSY_WAIT.
      do_reset(1);
      tm_en = 1'b0;
      TLU_TRIGGER = 1'b1;
      n = 0;
      while (!TLU_BUSY && n < 10) begin tick(); n++; end
      chk("tmo_busy_seen", 64'(TLU_BUSY), 64'd1);
      n = 0;
      while (!TIMEOUT_ERR && n < 40) begin tick(); n++; end
      chk("tmo_delay", 64'(n), 64'd15);
      chk("tmo_busy_dropped", 64'(TLU_BUSY), 64'd0);
      repeat (40) tick();
      chk("tmo_single_pulse", 64'(tmo_seen), 64'd1);
      chk("tmo_no_valid", 64'(vld_cyc), 64'd0);
      chk("tmo_trig_cnt", 64'(TRIG_CNT), 64'd0);
      TLU_TRIGGER = 1'b0;
      repeat (10) tick();
      tm_en = 1'b1;
      tm_start = 1;
      run_until_done(300);
      chk("tmo_recovery_cnt", 64'(TRIG_CNT), 64'd1);

      // SYS_RST in the middle of SHIFT, while TLU_CLOCK is high.
      do_reset(2);
      tm_start = 1;
      n = 0;
      while (!(rises >= 3 && TLU_CLOCK) && n < 400) begin tick(); n++; end
      chk("rst_mid_shift_reached", 64'(TLU_CLOCK), 64'd1);
      SYS_RST = 1'b1;
      #1;
      chk_all_zero("rst_mid_shift");
      model_reset();
      repeat (3) begin
         tick();
         chk("rst_clock_quiet", 64'(TLU_CLOCK), 64'd0);
      end
      SYS_RST = 1'b0;
      tick();
      tm_start = 1;
      run_until_done(600);
      chk("rst_restart_cnt", 64'(TRIG_CNT), 64'd1);
      chk("rst_restart_id", 64'(last_id), 64'd0);

      // Mode 0: ENABLE gating, dropped edge while pending, TLU_RESET clears the counter.
      do_reset(0);
      tm_en = 1'b0;
      TRIG_READY = 1'b0;
      ENABLE = 1'b0;
      pulse();
      chk("m0_disabled_no_valid", 64'(vld_cyc), 64'd0);
      ENABLE = 1'b1;
      exp_q.push_back(NB'(m_ctr)); m_ctr++;
      pulse();
      chk("m0_valid", 64'(TRIG_VALID), 64'd1);
      pulse();
      chk("m0_skip", 64'(SKIP_CNT), 64'd1);
      TRIG_READY = 1'b1;
      repeat (4) tick();
      chk("m0_cnt_1", 64'(TRIG_CNT), 64'd1);
      TLU_RESET = 1'b1;
      repeat (4) tick();
      TLU_RESET = 1'b0;
      repeat (4) tick();
      m_ctr = 0;
      exp_q.push_back(NB'(m_ctr)); m_ctr++;
      pulse();
      chk("m0_cnt_2", 64'(TRIG_CNT), 64'd2);
      chk("m0_id_after_tlu_reset", 64'(last_id), 64'd0);
      chk("m0_queue_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
